// File: rtl/wb_trace_fifo.sv
// Commit-trace FIFO for the miniCPU write-back debug port, drained through a
// first-word-fall-through valid/ready interface. Optional timestamps: WB_TRACE_TS_EN.
module wb_trace_fifo #(
  parameter int DEPTH  = 16,
  parameter int PC_W   = 32,
  parameter int DATA_W = 32,
  parameter int OVF_W  = 16,
  parameter int TS_W   = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    wb_have_inst,
  input  logic [PC_W-1:0]         wb_pc,
  input  logic                    wb_ena,
  input  logic [4:0]              wb_reg,
  input  logic [DATA_W-1:0]       wb_value,
  output logic                    rec_valid,
  input  logic                    rec_ready,
  output logic [PC_W-1:0]         rec_pc,
  output logic                    rec_ena,
  output logic [4:0]              rec_reg,
  output logic [DATA_W-1:0]       rec_value,
`ifdef WB_TRACE_TS_EN
  output logic [TS_W-1:0]         rec_ts,
`endif
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty,
  output logic                    overflow,
  output logic [OVF_W-1:0]        ovf_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TS_W < 1) || (OVF_W < 1)) begin : g_bad_param
    $error("wb_trace_fifo: DEPTH must be a power of two >= 2, TS_W and OVF_W >= 1");
  end

  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [AW-1:0]     wr_addr_s;
  logic [AW-1:0]     rd_addr_s;
  logic              empty_s;
  logic              full_s;
  logic              pop_s;
  logic              push_s;
  logic              drop_s;
  logic [4:0]        reg_canon_s;
  logic [DATA_W-1:0] val_canon_s;
  logic              overflow_r;
  logic [OVF_W-1:0]  ovf_cnt_r;

  logic [PC_W-1:0]   pc_mem_r  [DEPTH];
  logic              ena_mem_r [DEPTH];
  logic [4:0]        reg_mem_r [DEPTH];
  logic [DATA_W-1:0] val_mem_r [DEPTH];

  // Occupancy flags and handshake decode; a pop frees the slot a full push needs.
  always_comb begin
    wr_addr_s = wr_ptr_r[AW-1:0];
    rd_addr_s = rd_ptr_r[AW-1:0];
    empty_s   = (wr_ptr_r == rd_ptr_r);
    full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_addr_s == rd_addr_s);
    pop_s     = !empty_s && rec_ready;
    push_s    = wb_have_inst && (!full_s || pop_s);
    drop_s    = wb_have_inst && full_s && !pop_s;
  end

  // Non-writing commits are stored with reg/value zeroed so traces compare exactly.
  always_comb begin
    reg_canon_s = 5'd0;
    val_canon_s = {DATA_W{1'b0}};
    if (wb_ena) begin
      reg_canon_s = wb_reg;
      val_canon_s = wb_value;
    end else begin
      reg_canon_s = 5'd0;
      val_canon_s = {DATA_W{1'b0}};
    end
  end

  // Read/write pointers; clr discards any push or pop of its cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
    end else if (clr) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

  // Sticky drop flag and saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r <= 1'b0;
      ovf_cnt_r  <= {OVF_W{1'b0}};
    end else if (clr) begin
      overflow_r <= 1'b0;
      ovf_cnt_r  <= {OVF_W{1'b0}};
    end else if (drop_s) begin
      overflow_r <= 1'b1;
      if (ovf_cnt_r != {OVF_W{1'b1}}) begin
        ovf_cnt_r <= ovf_cnt_r + OVF_W'(1);
      end else begin
        ovf_cnt_r <= ovf_cnt_r;
      end
    end else begin
      overflow_r <= overflow_r;
      ovf_cnt_r  <= ovf_cnt_r;
    end
  end

  // Record storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s && !clr) begin
      pc_mem_r[wr_addr_s]  <= wb_pc;
      ena_mem_r[wr_addr_s] <= wb_ena;
      reg_mem_r[wr_addr_s] <= reg_canon_s;
      val_mem_r[wr_addr_s] <= val_canon_s;
    end
  end

`ifdef WB_TRACE_TS_EN
  logic [TS_W-1:0] ts_r;
  logic [TS_W-1:0] ts_mem_r [DEPTH];

  // Free-running cycle counter; deliberately untouched by clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_r <= {TS_W{1'b0}};
    end else begin
      ts_r <= ts_r + TS_W'(1);
    end
  end

  // Timestamp of the capture cycle travels with its record.
  always_ff @(posedge clk) begin
    if (push_s && !clr) begin
      ts_mem_r[wr_addr_s] <= ts_r;
    end
  end

  // Head timestamp, zeroed while empty.
  always_comb begin
    rec_ts = {TS_W{1'b0}};
    if (!empty_s) begin
      rec_ts = ts_mem_r[rd_addr_s];
    end else begin
      rec_ts = {TS_W{1'b0}};
    end
  end
`endif

  // Status outputs and fall-through head record, zeroed while empty to avoid X.
  always_comb begin
    rec_valid = !empty_s;
    count     = wr_ptr_r - rd_ptr_r;
    full      = full_s;
    empty     = empty_s;
    overflow  = overflow_r;
    ovf_cnt   = ovf_cnt_r;
    rec_pc    = {PC_W{1'b0}};
    rec_ena   = 1'b0;
    rec_reg   = 5'd0;
    rec_value = {DATA_W{1'b0}};
    if (!empty_s) begin
      rec_pc    = pc_mem_r[rd_addr_s];
      rec_ena   = ena_mem_r[rd_addr_s];
      rec_reg   = reg_mem_r[rd_addr_s];
      rec_value = val_mem_r[rd_addr_s];
    end else begin
      rec_pc    = {PC_W{1'b0}};
      rec_ena   = 1'b0;
      rec_reg   = 5'd0;
      rec_value = {DATA_W{1'b0}};
    end
  end

endmodule

// File: doc/wb_trace_fifo.md
Name: wb_trace_fifo

Overview:
- Parametrised commit-trace buffer attached to the miniCPU write-back debug ports (debug_wb_have_inst/pc/ena/reg/value).
- Captures one record per retired instruction into a DEPTH-entry FIFO.
- Host or testbench drains records through a valid/ready port, so trace comparison no longer has to match the CPU cycle by cycle.
- Counts records dropped on overflow; optional per-record cycle timestamp.

Parameters:
- DEPTH, 16, FIFO entries; power of two, >= 2
- PC_W, 32, width of stored PC
- DATA_W, 32, width of stored write-back value
- OVF_W, 16, width of the saturating overflow counter
- TS_W, 32, timestamp width (used only with WB_TRACE_TS_EN)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous flush: empties the FIFO and clears the overflow state
- wb_have_inst  in  1  a valid commit is present this cycle
- wb_pc  in  PC_W  PC of the committing instruction
- wb_ena  in  1  register-write enable of the commit
- wb_reg  in  5  destination register
- wb_value  in  DATA_W  value written
- rec_valid  out  1  head record available
- rec_ready  in  1  consumer accepts head record
- rec_pc  out  PC_W  head record PC
- rec_ena  out  1  head record write enable
- rec_reg  out  5  head record register
- rec_value  out  DATA_W  head record value
- rec_ts  out  TS_W  head record timestamp (present only with WB_TRACE_TS_EN)
- count  out  log2(DEPTH)+1  current occupancy
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- overflow  out  1  sticky: at least one record dropped
- ovf_cnt  out  OVF_W  number of dropped records, saturating at all-ones

Behaviour:
- Reset (rst_n low, asynchronous):
  - read and write pointers cleared
  - count=0, empty=1, full=0, rec_valid=0
  - overflow=0, ovf_cnt=0, timestamp counter=0
  - storage contents are don't-care; rec_* data outputs read 0 while empty.
- Pointers are log2(DEPTH)+1 bits and wrap naturally. full/empty are decoded from the MSB and the address bits.
- Read side is first-word fall-through:
  - rec_valid = !empty
  - rec_* show the head entry combinationally from storage
- Pop: rec_valid && rec_ready at a rising edge. The read pointer advances, and the next entry appears in the same cycle the edge completes.
- Push: wb_have_inst at a rising edge, subject to the space rule below. Latency from the commit edge to rec_valid high (FIFO previously empty) is 1 cycle.
- Push when full:
  - with a pop in the same cycle, the push is accepted and count is unchanged
  - without a pop, the record is dropped: overflow <= 1, and ovf_cnt increments unless already all-ones
- Push and pop in the same cycle when not full and not empty: both take effect, count unchanged.
- Push when empty with rec_ready high: the record is written. It is not popped that cycle, because rec_valid was 0.
- Canonicalisation: if wb_ena=0, the record stores reg=0 and value=0, making traces deterministic. The PC is always stored.
- clr has priority over every other action in its cycle:
  - pointers reset, overflow=0, ovf_cnt=0
  - any push or pop in that cycle is discarded and not counted as an overflow
  - the timestamp counter is not affected by clr
- count = write pointer − read pointer (modulo 2·DEPTH). It is registered via the pointers, and outputs update on the edge that performs the operation.
- No X propagation: the data outputs are forced to 0 while empty.

Optional Feature:
- Macro WB_TRACE_TS_EN.
- When defined:
  - a TS_W-bit free-running cycle counter exists; it resets to 0, increments every clock, and wraps at 2^TS_W
  - each pushed record stores the counter value of its capture cycle
  - the rec_ts port exists and shows the head record's timestamp
- When undefined: no counter, no rec_ts port, no timestamp storage; all other behaviour is identical.

Test Plan:
- Reset then 3 consecutive commits (pc=0x0, 0x4, 0x8; ena=1; reg=1,2,3; value=0x11,0x22,0x33) with rec_ready=0 -> count=3. Then hold rec_ready=1 -> records pop in order, one per cycle, and empty=1 after the third.
- Commit with ena=0, reg=7, value=0xDEAD -> stored record has rec_ena=0, rec_reg=0, rec_value=0, and rec_pc correct.
- DEPTH=4: 6 commits with rec_ready=0 -> full=1, count=4, overflow=1, ovf_cnt=2. The drained records are the first 4 PCs.
- When full, commit and rec_ready=1 in the same cycle -> count stays 4, ovf_cnt unchanged, and the new record is last in drain order.
- Assert clr while count=3 and a commit is present -> next cycle empty=1, count=0, overflow=0, ovf_cnt=0; the commit is not stored.
- With WB_TRACE_TS_EN: deassert reset, commit at cycles 5 and 9 after the reset release -> rec_ts=5 then 9. With TS_W=4, a commit at cycle 17 -> rec_ts=1. Also assert rst_n low mid-drain -> all outputs return to reset values immediately.
